cp40_sequencer: RTL and testbench
=================================

// Module: cp40_sequencer
// PURPOSE
//  Upstream command sequencer for cryptoprocessor_wrapper_40. A host first writes a short program of
//  24-bit commands, then pulses start. The block then issues one command per cycle to the wrapper.
//  It pulls operand share pairs for LOAD from a valid/ready stream.
//  It captures the wrapper's dout_1/dout_2 for OUTPUT commands into a valid/ready result stream.
// PARAMETERS
//  W          40  share width (din/dout)
//  CMD_W      24  command width
//  PROG_DEPTH 64  program words; PA=$clog2(PROG_DEPTH)
//  RD_LAT     1   cycles from get_output sampled by wrapper to dout valid
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  prog_we     in   1      program write strobe (honoured only when !busy)
//  prog_addr   in   PA     program write address
//  prog_wdata  in   CMD_W  program word
//  prog_len    in   PA+1   number of words to run, sampled on start
//  start       in   1      begin execution at pc=0 (ignored while busy)
//  op_valid    in   1      operand pair available
//  op_ready    out  1      operand pair consumed this cycle
//  op_d1/op_d2 in   W      operand shares
//  res_valid   out  1      result pair available
//  res_ready   in   1      result pair accepted
//  res_d1/res_d2 out W     result shares (value = res_d1+res_d2 mod p)
//  get_output,data_en,ins_in out 1; command_in out CMD_W; din_1,din_2 out W: to wrapper
//  dout_1,dout_2 in W      from wrapper
//  busy        out  1      RUN/WAIT/DRAIN
//  done        out  1      one-cycle pulse at end of program
//  err         out  1      sticky: prog_we while busy; cleared by start or rst
// BEHAVIOUR
//  Encoding: op=[23:21], src1=[20:14], src2=[13:7], dst=[6:0].
//   Ops: 0 OUTPUT(src1), 1 LOAD(dst), 2 COPY, 3 ADD, 4 SUB, 5 MUL, 6 WAIT(cnt=[13:0]), 7 HALT.
//  Reset: all outputs 0; state IDLE; pc=0; result FIFO empty.
//   Program memory is not reset and retains its contents.
//  Wrapper outputs are registered, so a command reaches the wrapper the cycle after it is issued.
//   In any non-issue cycle all wrapper outputs are 0.
//  Issue rules per op:
//   - OUTPUT: get_output=1, ins_in=0, command_in=word. Issued only if fifo_cnt+pending<2.
//   - LOAD: op_ready=1 (combinational) while RUN && word is LOAD.
//     On op_valid&&op_ready: data_en=1, ins_in=1, din=op_d*. Otherwise stall with pc held.
//   - ops 2..5: ins_in=1, command_in=word.
//   - WAIT: no issue; idle cnt+1 cycles, then pc+1.
//   - HALT: enter DRAIN.
//  FSM:
//   - IDLE -> RUN on start. If prog_len==0, go to DRAIN instead.
//   - RUN -> WAIT on WAIT word.
//   - RUN -> DRAIN on HALT, or on issuing the word at pc==prog_len-1.
//   - WAIT -> RUN when the counter expires.
//   - DRAIN -> IDLE once pending==0 and the FIFO is empty. done pulses on that transition.
//  Read capture: a pending shift register of length RD_LAT+1 tracks issued OUTPUTs.
//   dout is pushed into the FIFO exactly RD_LAT+1 cycles after the issue cycle (1 for the output register).
//   Capture never drops data because credits are reserved at issue.
//  Result FIFO: 2 entries, first-word-fall-through. Simultaneous push and pop when full is legal.
//  No data-hazard checks are made. Programs insert WAIT after MUL as the wrapper latency requires.
//  rst mid-run: immediate return to IDLE. Outputs are 0 the next cycle, pending captures are discarded, and done is not pulsed.
//  start while busy: ignored. prog_we while busy: write dropped and err set.
// STRUCTURE
//  cp40_pkg:
//   - opcode localparams OP_OUTPUT..OP_HALT
//   - field slice positions
//   - cmd_t packed struct {op,src1,src2,dst}
//   - function mk_cmd()
//  Sub-module cp40_result_fifo: 2-deep, width 2*W, valid/ready, count output.
//  Top level contains the FSM, pc, WAIT counter, pending shift register and output registers.
// TESTING
//  1. Program 200000,200001,400002,600003,80C084,A08085,C00010,000000,004000,008000,00C000,010000,014000,E00000.
//     Random operands; p=574448099311.
//     -> 6 results. Check sum mod p: a, b, a, 2a, 2a-b, a*b*25304611676 mod p. done pulses once.
//  2. Same program with op_valid low for 5 cycles before the 2nd LOAD.
//     -> pc holds, no wrapper strobes during the stall, results unchanged.
//  3. res_ready=0 across 4 OUTPUTs.
//     -> at most 2 OUTPUTs issued. After res_ready=1, all 4 results arrive in order with none lost.
//  4. prog_len=3 with no HALT.
//     -> exactly 3 issues, then done. prog_len=0 -> done 2 cycles after start, no issue.
//  5. rst asserted during WAIT.
//     -> next cycle: busy=0, all outputs 0, no done. Restart gives correct results from the retained program.
//  6. prog_we while busy.
//     -> err=1, the program word is unchanged (checked by rerun); start clears err.

Source files
------------

// File: rtl/cp40_pkg.sv
// cp40_pkg: shared definitions for the cryptoprocessor_wrapper_40 command sequencer.
//   - opcode values carried in command bits [23:21]
//   - bit positions of the command fields
//   - cmd_t packed view of a command word and mk_cmd() to build one
//   - sequencer FSM state encoding
package cp40_pkg;

    localparam logic [2:0] OP_OUTPUT = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_COPY   = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_SUB    = 3'd4;
    localparam logic [2:0] OP_MUL    = 3'd5;
    localparam logic [2:0] OP_WAIT   = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    localparam int OP_HI   = 23;
    localparam int OP_LO   = 21;
    localparam int SRC1_HI = 20;
    localparam int SRC1_LO = 14;
    localparam int SRC2_HI = 13;
    localparam int SRC2_LO = 7;
    localparam int DST_HI  = 6;
    localparam int DST_LO  = 0;
    // WAIT reuses src2 and dst as one 14-bit idle count
    localparam int WCNT_HI = 13;
    localparam int WCNT_LO = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [6:0] src1;
        logic [6:0] src2;
        logic [6:0] dst;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic [23:0] mk_cmd(input logic [2:0] op, input logic [6:0] src1,
                                           input logic [6:0] src2, input logic [6:0] dst);
        cmd_t c;
        c.op   = op;
        c.src1 = src1;
        c.src2 = src2;
        c.dst  = dst;
        return c;
    endfunction

endpackage

// File: rtl/cp40_result_fifo.sv
// cp40_result_fifo: 2-entry first-word-fall-through FIFO for captured result share pairs.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push       write push_data (dropped only if full and not popping)
//   push_data  DW-bit entry
//   pop        consume the head entry (ignored when empty)
//   valid      head entry present
//   data       head entry, forced to 0 while empty
//   count      number of stored entries (0..2)
module cp40_result_fifo #(
    parameter int DW = 80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // When full, a simultaneous pop frees the head slot, which is the slot wr_ptr points at.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign valid = (count != 2'd0);
    assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cp40_sequencer.sv
// cp40_sequencer: command sequencer in front of cryptoprocessor_wrapper_40.
// A host writes a program of CMD_W-bit commands while idle, then pulses start; one command
// per cycle is issued to the wrapper through registered outputs.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   prog_we/addr/wdata        program write port (dropped and err set while busy)
//   prog_len                  words to run, sampled on start
//   start                     begin at pc=0 (ignored while busy)
//   op_valid/op_ready/op_d1/2 operand share stream consumed by LOAD
//   res_valid/res_ready/res_d1/2  captured OUTPUT share pairs
//   get_output, data_en, ins_in, command_in, din_1, din_2  to wrapper (registered)
//   dout_1, dout_2            from wrapper, valid RD_LAT cycles after get_output
//   busy, done, err           status: running, end-of-program pulse, sticky write error
module cp40_sequencer
    import cp40_pkg::*;
#(
    parameter int W          = 40,
    parameter int CMD_W      = 24,
    parameter int PROG_DEPTH = 64,
    parameter int RD_LAT     = 1,
    localparam int PA        = $clog2(PROG_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [PA-1:0]    prog_addr,
    input  logic [CMD_W-1:0] prog_wdata,
    input  logic [PA:0]      prog_len,
    input  logic             start,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W-1:0]     op_d1,
    input  logic [W-1:0]     op_d2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_d1,
    output logic [W-1:0]     res_d2,
    output logic             get_output,
    output logic             data_en,
    output logic             ins_in,
    output logic [CMD_W-1:0] command_in,
    output logic [W-1:0]     din_1,
    output logic [W-1:0]     din_2,
    input  logic [W-1:0]     dout_1,
    input  logic [W-1:0]     dout_2,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [CMD_W-1:0] prog_mem [PROG_DEPTH];

    state_t           state;
    logic [PA-1:0]    pc;
    logic [PA:0]      len;
    logic [13:0]      wait_cnt;
    // bit k set: an OUTPUT was issued k+1 cycles ago and its dout is still on the way
    logic [RD_LAT:0]  pend;

    logic [CMD_W-1:0] cur_word;
    logic [2:0]       cur_op;
    logic             last_word;
    int               pend_cnt;
    logic             out_credit;
    logic             iss_out;
    logic             iss_load;
    logic             iss_alu;
    logic             advance;

    logic [1:0]       fifo_cnt;
    logic [2*W-1:0]   res_data;

    assign cur_word  = prog_mem[pc];
    assign cur_op    = cur_word[OP_HI:OP_LO];
    assign last_word = ((PA+1)'(pc) == (len - (PA+1)'(1)));
    assign busy      = (state != S_IDLE);
    assign op_ready  = (state == S_RUN) && (cur_op == OP_LOAD);

    always_ff @(posedge clk) begin
        if (prog_we && !busy) prog_mem[prog_addr] <= prog_wdata;
    end

    // An OUTPUT is only issued when a FIFO slot is guaranteed for its capture, so the
    // capture path never has to drop data.
    always_comb begin
        pend_cnt = 0;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (pend[i]) pend_cnt = pend_cnt + 1;
        end
        out_credit = (int'(fifo_cnt) + pend_cnt) < 2;
    end

    always_comb begin
        iss_out  = 1'b0;
        iss_load = 1'b0;
        iss_alu  = 1'b0;
        if (state == S_RUN) begin
            case (cur_op)
                OP_OUTPUT: iss_out  = out_credit;
                OP_LOAD:   iss_load = op_valid;
                OP_COPY, OP_ADD, OP_SUB, OP_MUL: iss_alu = 1'b1;
                default: ;
            endcase
        end
        advance = iss_out || iss_load || iss_alu;
    end

    // ---- issue stage -> wrapper output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            len        <= '0;
            wait_cnt   <= '0;
            pend       <= '0;
            get_output <= 1'b0;
            data_en    <= 1'b0;
            ins_in     <= 1'b0;
            command_in <= '0;
            din_1      <= '0;
            din_2      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // wrapper strobes and data are zero in every non-issue cycle
            get_output <= 1'b0;
            data_en    <= 1'b0;
            ins_in     <= 1'b0;
            command_in <= '0;
            din_1      <= '0;
            din_2      <= '0;
            done       <= 1'b0;
            pend       <= {pend[RD_LAT-1:0], iss_out};

            if (prog_we && busy) err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        pc    <= '0;
                        len   <= prog_len;
                        state <= (prog_len == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (iss_out) begin
                        get_output <= 1'b1;
                        command_in <= cur_word;
                    end
                    if (iss_load) begin
                        data_en    <= 1'b1;
                        ins_in     <= 1'b1;
                        command_in <= cur_word;
                        din_1      <= op_d1;
                        din_2      <= op_d2;
                    end
                    if (iss_alu) begin
                        ins_in     <= 1'b1;
                        command_in <= cur_word;
                    end
                    if (cur_op == OP_WAIT) begin
                        wait_cnt <= cur_word[WCNT_HI:WCNT_LO];
                        state    <= S_WAIT;
                    end else if (cur_op == OP_HALT) begin
                        state <= S_DRAIN;
                    end else if (advance) begin
                        if (last_word) state <= S_DRAIN;
                        else           pc    <= pc + PA'(1);
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 14'd0) begin
                        if (last_word) begin
                            state <= S_DRAIN;
                        end else begin
                            pc    <= pc + PA'(1);
                            state <= S_RUN;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 14'd1;
                    end
                end
                S_DRAIN: begin
                    if ((pend_cnt == 0) && (fifo_cnt == 2'd0)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- capture stage: dout arrives RD_LAT+1 cycles after the issue cycle ----
    cp40_result_fifo #(
        .DW(2*W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend[RD_LAT]),
        .push_data ({dout_1, dout_2}),
        .pop       (res_valid && res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .count     (fifo_cnt)
    );

    assign res_d1 = res_data[2*W-1:W];
    assign res_d2 = res_data[W-1:0];

endmodule

// File: tb/tb_cp40_sequencer.sv
// tb_cp40_sequencer: directed scenarios with random operand/share values for cp40_sequencer.
// A behavioural wrapper model executes issued commands on values mod p; expected results are
// computed directly from the operand values.
module tb_cp40_sequencer;
    import cp40_pkg::*;

    localparam int W = 40;
    localparam int CMD_W = 24;
    localparam int PA = 6;
    localparam logic [127:0] P    = 128'd574448099311;
    localparam logic [127:0] KMUL = 128'd25304611676;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             prog_we = 1'b0;
    logic [PA-1:0]    prog_addr = '0;
    logic [CMD_W-1:0] prog_wdata = '0;
    logic [PA:0]      prog_len = '0;
    logic             start = 1'b0;
    logic             op_valid;
    logic             op_ready;
    logic [W-1:0]     op_d1;
    logic [W-1:0]     op_d2;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [W-1:0]     res_d1;
    logic [W-1:0]     res_d2;
    logic             get_output;
    logic             data_en;
    logic             ins_in;
    logic [CMD_W-1:0] command_in;
    logic [W-1:0]     din_1;
    logic [W-1:0]     din_2;
    logic [W-1:0]     dout_1 = '0;
    logic [W-1:0]     dout_2 = '0;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    cp40_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_len(prog_len), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .op_d1(op_d1), .op_d2(op_d2), .res_valid(res_valid), .res_ready(res_ready),
        .res_d1(res_d1), .res_d2(res_d2), .get_output(get_output), .data_en(data_en),
        .ins_in(ins_in), .command_in(command_in), .din_1(din_1), .din_2(din_2),
        .dout_1(dout_1), .dout_2(dout_2), .busy(busy), .done(done), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [39:0] md(input logic [127:0] x);
        return 40'(x % P);
    endfunction

    function automatic logic [39:0] rand_modp();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return 40'(r % 64'd574448099311);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- wrapper model ----------------
    logic [39:0] wreg [128];
    logic [39:0] shr;
    initial for (int i = 0; i < 128; i++) wreg[i] = '0;

    always @(posedge clk) begin
        if (ins_in) begin
            case (command_in[23:21])
                OP_LOAD: if (data_en) wreg[command_in[6:0]] <= md(128'(din_1) + 128'(din_2));
                OP_COPY: wreg[command_in[6:0]] <= wreg[command_in[20:14]];
                OP_ADD:  wreg[command_in[6:0]] <= md(128'(wreg[command_in[20:14]]) + 128'(wreg[command_in[13:7]]));
                OP_SUB:  wreg[command_in[6:0]] <= md(128'(wreg[command_in[20:14]]) + P - 128'(wreg[command_in[13:7]]));
                OP_MUL:  wreg[command_in[6:0]] <= md(128'(md(128'(wreg[command_in[20:14]]) * 128'(wreg[command_in[13:7]]))) * KMUL);
                default: ;
            endcase
        end
        if (get_output) begin
            shr = rand_modp();
            dout_1 <= shr;
            dout_2 <= md(128'(wreg[command_in[20:14]]) + P - 128'(shr));
        end
    end

    // ---------------- operand source ----------------
    logic [79:0] op_q[$];
    int op_idx = 0;
    int stall_at = -1;
    int stall_len = 0;

    initial begin
        bit fire;
        int hold;
        hold = 0;
        op_valid = 1'b0;
        op_d1 = '0;
        op_d2 = '0;
        forever begin
            @(negedge clk);
            fire = op_valid && op_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                op_idx++;
                if (op_idx == stall_at) hold = stall_len;
            end
            if (hold > 0) begin
                hold--;
                op_valid = 1'b0;
            end else if (op_idx < op_q.size()) begin
                op_valid = 1'b1;
                {op_d1, op_d2} = op_q[op_idx];
            end else begin
                op_valid = 1'b0;
            end
        end
    end

    // ---------------- result sink and monitors ----------------
    logic [39:0] rx_q[$];
    int rx_base = 0;
    int n_out = 0, n_ins = 0, n_done = 0, n_stall = 0, n_stall_strobe = 0;

    initial begin
        bit prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) rx_q.push_back(md(128'(res_d1) + 128'(res_d2)));
            if (get_output) n_out++;
            if (ins_in) n_ins++;
            if (done) n_done++;
            if (prev_stall && (get_output || ins_in || data_en)) n_stall_strobe++;
            prev_stall = busy && op_ready && !op_valid;
            if (prev_stall) n_stall++;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [23:0] words[$]);
        foreach (words[i]) begin
            prog_we = 1'b1;
            prog_addr = PA'(i);
            prog_wdata = words[i];
            tick(1);
        end
        prog_we = 1'b0;
    endtask

    task automatic push_val(input logic [39:0] v);
        logic [39:0] d1;
        d1 = rand_modp();
        op_q.push_back({d1, md(128'(v) + P - 128'(d1))});
    endtask

    task automatic pulse_start(input logic [PA:0] len);
        prog_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int c;
        c = 0;
        while (n_done == d0 && c < budget) begin
            tick(1);
            c++;
        end
        tick(3);
        check({tag, "_done_once"}, 64'(n_done - d0), 64'd1);
    endtask

    task automatic check_results(input string tag, input logic [39:0] exp[$]);
        check({tag, "_count"}, 64'(rx_q.size() - rx_base), 64'(exp.size()));
        foreach (exp[i]) begin
            if (rx_base + i < rx_q.size())
                check($sformatf("%s_res%0d", tag, i), 64'(rx_q[rx_base + i]), 64'(exp[i]));
        end
        rx_base = rx_q.size();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({op_ready, res_valid, get_output, data_en, ins_in, busy, done}), 64'd0);
        check({tag, "_cmd"}, 64'(command_in), 64'd0);
        check({tag, "_din"}, 64'(din_1 | din_2), 64'd0);
        check({tag, "_res"}, 64'(res_d1 | res_d2), 64'd0);
    endtask

    function automatic void exp_prog1(input logic [39:0] a, input logic [39:0] b, output logic [39:0] e[$]);
        e = {};
        e.push_back(a);
        e.push_back(b);
        e.push_back(a);
        e.push_back(md(128'(a) * 2));
        e.push_back(md(128'(a) * 2 + P - 128'(b)));
        e.push_back(md(128'(md(128'(a) * 128'(b))) * KMUL));
    endfunction

    task automatic run_prog1(input string tag);
        logic [39:0] a, b;
        logic [39:0] e[$];
        int d0;
        a = rand_modp();
        b = rand_modp();
        push_val(a);
        push_val(b);
        tick(2);
        d0 = n_done;
        pulse_start(7'd14);
        wait_done(tag, d0, 300);
        exp_prog1(a, b, e);
        check_results(tag, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [23:0] prog1[$];
        logic [23:0] prog3[$];
        logic [23:0] prog4[$];
        logic [39:0] a, b;
        logic [39:0] e[$];
        int d0, s0, st0;

        prog1 = {24'h200000, 24'h200001, 24'h400002, 24'h600003, 24'h80C084, 24'hA08085, 24'hC00010,
                 24'h000000, 24'h004000, 24'h008000, 24'h00C000, 24'h010000, 24'h014000, 24'hE00000};

        // reset state
        tick(3);
        rst = 1'b0;
        check_quiet("reset");
        check("reset_err", 64'(err), 64'd0);

        // 1: full program
        load_prog(prog1);
        run_prog1("prog1");

        // 2: operand stall before the second LOAD
        st0 = n_stall;
        s0 = n_stall_strobe;
        stall_len = 5;
        stall_at = op_q.size() + 1;
        run_prog1("stall");
        stall_at = -1;
        check("stall_cycles", 64'(n_stall - st0), 64'd5);
        check("stall_strobes", 64'(n_stall_strobe - s0), 64'd0);

        // 3: result backpressure across four OUTPUTs
        prog3 = {mk_cmd(OP_LOAD, 7'd0, 7'd0, 7'd0), mk_cmd(OP_LOAD, 7'd0, 7'd0, 7'd1),
                 mk_cmd(OP_OUTPUT, 7'd0, 7'd0, 7'd0), mk_cmd(OP_OUTPUT, 7'd1, 7'd0, 7'd0),
                 mk_cmd(OP_OUTPUT, 7'd0, 7'd0, 7'd0), mk_cmd(OP_OUTPUT, 7'd1, 7'd0, 7'd0),
                 mk_cmd(OP_HALT, 7'd0, 7'd0, 7'd0)};
        load_prog(prog3);
        a = rand_modp();
        b = rand_modp();
        push_val(a);
        push_val(b);
        tick(2);
        res_ready = 1'b0;
        s0 = n_out;
        d0 = n_done;
        pulse_start(7'd7);
        tick(30);
        check("bp_outputs_issued", 64'(n_out - s0), 64'd2);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        wait_done("bp", d0, 100);
        e = {a, b, a, b};
        check_results("bp", e);

        // 4: prog_len=3 without HALT, then prog_len=0
        prog4 = {mk_cmd(OP_LOAD, 7'd0, 7'd0, 7'd0), mk_cmd(OP_COPY, 7'd0, 7'd0, 7'd1),
                 mk_cmd(OP_OUTPUT, 7'd1, 7'd0, 7'd0)};
        load_prog(prog4);
        a = rand_modp();
        push_val(a);
        tick(2);
        s0 = n_out + n_ins;
        d0 = n_done;
        pulse_start(7'd3);
        wait_done("len3", d0, 100);
        check("len3_issues", 64'(n_out + n_ins - s0), 64'd3);
        e = {a};
        check_results("len3", e);

        s0 = n_out + n_ins;
        d0 = n_done;
        prog_len = 7'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("len0_cyc1", 64'({busy, done}), 64'b10);
        tick(1);
        check("len0_cyc2", 64'({busy, done}), 64'b01);
        tick(3);
        check("len0_issues", 64'(n_out + n_ins - s0), 64'd0);
        check("len0_done_once", 64'(n_done - d0), 64'd1);

        // 5: reset during WAIT, then rerun from retained program
        load_prog(prog1);
        a = rand_modp();
        b = rand_modp();
        push_val(a);
        push_val(b);
        tick(2);
        d0 = n_done;
        pulse_start(7'd14);
        tick(12);
        check("rst_in_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_quiet("rst_mid");
        tick(30);
        check("rst_no_done", 64'(n_done - d0), 64'd0);
        check("rst_no_results", 64'(rx_q.size() - rx_base), 64'd0);
        run_prog1("rst_rerun");

        // 6: program write while busy
        a = rand_modp();
        b = rand_modp();
        push_val(a);
        push_val(b);
        tick(2);
        d0 = n_done;
        pulse_start(7'd14);
        tick(12);
        prog_we = 1'b1;
        prog_addr = 6'd8;
        prog_wdata = 24'hE00000;
        tick(1);
        prog_we = 1'b0;
        check("we_busy_err", 64'(err), 64'd1);
        wait_done("we_busy", d0, 300);
        exp_prog1(a, b, e);
        check_results("we_busy", e);
        check("we_err_sticky", 64'(err), 64'd1);
        a = rand_modp();
        b = rand_modp();
        push_val(a);
        push_val(b);
        tick(2);
        d0 = n_done;
        pulse_start(7'd14);
        check("start_clears_err", 64'(err), 64'd0);
        wait_done("we_rerun", d0, 300);
        exp_prog1(a, b, e);
        check_results("we_rerun", e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
